dac_sample_sched: RTL and testbench
===================================

Name: dac_sample_sched

Overview:
- Sequences PLL bring-up and schedules samples into the 10-bit DAC data input.
- Drives the PLL active-low enables (ENb_VCO, then ENb_CP) with programmable settle delays. While the PLL is starting up, holds the DAC at midscale.
- In RUN, issues a sample slot every DIV+1 cycles and arbitrates two valid/ready sample sources (A: core waveform, B: LA/test pattern) onto the DAC input.
- Runs on the reference clock, not on the PLL output.

Parameters:
DW, 10, DAC data width
DIV_W, 16, width of sample-rate divider
SETTLE_W, 12, width of settle counters
MIDSCALE, 10'h200, DAC code driven when not running

Ports:
CLK  input  1  reference clock
reset  input  1  asynchronous active-low reset
enable  input  1  1 = bring up PLL and run; 0 = shut down
vco_settle  input  SETTLE_W  cycles to wait after ENb_VCO low
cp_settle  input  SETTLE_W  cycles to wait after ENb_CP low
div  input  DIV_W  sample period minus one
prio_a  input  1  1 = fixed priority to A; 0 = round-robin
a_valid  input  1  source A has a sample
a_data  input  DW  source A sample
a_ready  output  1  source A sample accepted this cycle
b_valid  input  1  source B has a sample
b_data  input  DW  source B sample
b_ready  output  1  source B sample accepted this cycle
enb_vco  output  1  PLL VCO enable, active-low
enb_cp  output  1  PLL charge-pump enable, active-low
dac_d  output  DW  registered DAC code
running  output  1  state == RUN
underrun_cnt  output  8  empty sample slots, saturating

Behaviour:
- Reset values (reset low, asynchronous):
  - state=OFF
  - enb_vco=1, enb_cp=1
  - dac_d=MIDSCALE
  - a_ready=0, b_ready=0
  - running=0
  - underrun_cnt=0
  - rr pointer=B (so A wins the first round-robin slot)
  - divider counter=0
- FSM, one transition per cycle:
  - OFF: when enable=1, go to VCO_UP. Load the settle counter with vco_settle; enb_vco goes 0 on entry.
  - VCO_UP: decrement the counter. When it reaches 0, go to CP_UP, load cp_settle, and drive enb_cp=0.
  - CP_UP: decrement the counter. When it reaches 0, go to RUN and load the divider counter with div.
  - RUN: running=1.
  - A settle value of 0 means exactly one cycle in that state.
  - enable=0 in any non-OFF state: next cycle state=OFF, enb_cp=1, enb_vco=1, dac_d=MIDSCALE, ready outputs=0. Counters clear.
  - underrun_cnt is retained across enable=0; only reset clears it.
- Sample tick, RUN only:
  - Tick occurs when the divider counter == 0. The counter then reloads from div as sampled that cycle; otherwise it decrements.
  - div=0 gives a tick every cycle.
  - A change to div takes effect at the next reload.
- Arbitration on a tick cycle (combinational ready, Moore on state):
  - prio_a=1: grant A if a_valid, else B if b_valid.
  - prio_a=0: grant the valid source that is not the rr pointer. If only one source is valid, grant it. The rr pointer updates to the granted source.
  - Exactly one of a_ready/b_ready is high, and only if the granted source is valid. Transfer = valid & ready.
  - No ready is asserted outside tick cycles, or outside RUN.
- dac_d:
  - Registers the granted data on the cycle after the transfer, so latency is 1 from the tick.
  - Holds its value between ticks.
- Underrun: a tick with neither source valid keeps dac_d unchanged and increments underrun_cnt, which saturates at 8'hFF.
- Simultaneous events:
  - enable falling on a tick cycle: no transfer; shutdown takes priority.
  - Sources may drop valid without a handshake; no state is kept for them.

Test Plan:
- Reset mid-RUN with dac_d=10'h3FF → all outputs return to reset values immediately, asynchronously; dac_d=10'h200, enb_vco=enb_cp=1.
- enable=1, vco_settle=3, cp_settle=2 → enb_vco falls 1 cycle after enable; enb_cp falls 4 cycles later; running rises 3 cycles after that; dac_d=10'h200 throughout.
- RUN, div=3, prio_a=0, both sources always valid (a_data=10'h011, b_data=10'h022) → ready pulses every 4 cycles, alternating A,B,A,B with A first; dac_d sequence 011,022,011,… updating one cycle after each pulse.
- RUN, div=0, prio_a=1, a_valid toggling each cycle, b_valid=1 → a_ready on every A-valid cycle and b_ready on the others; no underrun.
- RUN, div=1, both sources invalid for 300 ticks → dac_d holds its last value; underrun_cnt saturates at 8'hFF.
- enable dropped on a tick cycle with a_valid=1 → no a_ready; next cycle state=OFF, dac_d=10'h200, enables=1; underrun_cnt unchanged.

Source files
------------

// File: rtl/dac_sample_sched.sv
// dac_sample_sched: PLL bring-up sequencer and DAC sample scheduler.
// Runs on the reference clock. Brings the PLL up in two steps (ENb_VCO,
// then ENb_CP), each followed by a programmable settle time, and holds the
// DAC at midscale until RUN. In RUN it opens a sample slot every div+1
// cycles and arbitrates two valid/ready sources onto the DAC register.
// Ports:
//   CLK, reset          reference clock, async active-low reset
//   enable              1 = bring up and run, 0 = shut down
//   vco_settle          settle cycles after ENb_VCO falls
//   cp_settle           settle cycles after ENb_CP falls
//   div                 sample period minus one
//   prio_a              1 = fixed priority to A, 0 = round-robin
//   a_valid/a_data/a_ready   source A (core waveform)
//   b_valid/b_data/b_ready   source B (LA / test pattern)
//   enb_vco, enb_cp     PLL enables, active-low
//   dac_d               registered DAC code
//   running             high while in RUN
//   underrun_cnt        saturating count of empty sample slots
module dac_sample_sched #(
    parameter int unsigned   DW       = 10,
    parameter int unsigned   DIV_W    = 16,
    parameter int unsigned   SETTLE_W = 12,
    parameter logic [DW-1:0] MIDSCALE = DW'(10'h200)
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic [SETTLE_W-1:0] vco_settle,
    input  logic [SETTLE_W-1:0] cp_settle,
    input  logic [DIV_W-1:0]    div,
    input  logic                prio_a,
    input  logic                a_valid,
    input  logic [DW-1:0]       a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [DW-1:0]       b_data,
    output logic                b_ready,
    output logic                enb_vco,
    output logic                enb_cp,
    output logic [DW-1:0]       dac_d,
    output logic                running,
    output logic [7:0]          underrun_cnt
);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_VCO_UP = 2'd1,
        S_CP_UP  = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                rr_is_b;
    logic                tick;
    logic                grant_a;
    logic                grant_b;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_OFF;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; dropping enable returns to OFF from any state
    always_comb begin
        state_nx = state;
        case (state)
            S_OFF: begin
                if (enable) state_nx = S_VCO_UP;
            end
            S_VCO_UP: begin
                if (!enable)                  state_nx = S_OFF;
                else if (settle_cnt == '0)    state_nx = S_CP_UP;
            end
            S_CP_UP: begin
                if (!enable)                  state_nx = S_OFF;
                else if (settle_cnt == '0)    state_nx = S_RUN;
            end
            S_RUN: begin
                if (!enable)                  state_nx = S_OFF;
            end
            default: state_nx = S_OFF;
        endcase
    end

    // Outputs: PLL enables decoded from state, ready only on a live tick
    always_comb begin
        enb_vco = 1'b1;
        enb_cp  = 1'b1;
        running = 1'b0;
        tick    = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            S_OFF: begin
            end
            S_VCO_UP: begin
                enb_vco = 1'b0;
            end
            S_CP_UP: begin
                enb_vco = 1'b0;
                enb_cp  = 1'b0;
            end
            S_RUN: begin
                enb_vco = 1'b0;
                enb_cp  = 1'b0;
                running = 1'b1;
                // Shutdown wins over a slot that coincides with enable falling
                tick    = enable && (div_cnt == '0);
            end
            default: begin
            end
        endcase

        // Round-robin hands a contested slot to the source not granted last
        if (prio_a) begin
            grant_a = a_valid;
            grant_b = !a_valid && b_valid;
        end else begin
            grant_a = a_valid && (!b_valid || rr_is_b);
            grant_b = b_valid && (!a_valid || !rr_is_b);
        end

        a_ready = tick && grant_a;
        b_ready = tick && grant_b;
    end

    // Settle counter: loaded on entry to each bring-up step, counts down to 0
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
        end else if (!enable) begin
            settle_cnt <= '0;
        end else begin
            case (state)
                S_OFF:    settle_cnt <= vco_settle;
                S_VCO_UP: settle_cnt <= (settle_cnt == '0) ? cp_settle
                                                           : settle_cnt - SETTLE_W'(1);
                S_CP_UP:  settle_cnt <= (settle_cnt == '0) ? '0
                                                           : settle_cnt - SETTLE_W'(1);
                default:  settle_cnt <= '0;
            endcase
        end
    end

    // Sample divider: loaded with div on entry to RUN, reloads on each slot
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
        end else if (state == S_CP_UP && settle_cnt == '0) begin
            div_cnt <= div;
        end else if (state == S_RUN) begin
            div_cnt <= (div_cnt == '0) ? div : div_cnt - DIV_W'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    // Round-robin pointer follows the last source granted in round-robin mode
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rr_is_b <= 1'b1;
        end else if (!prio_a) begin
            if (a_ready)      rr_is_b <= 1'b0;
            else if (b_ready) rr_is_b <= 1'b1;
        end
    end

    // DAC register: midscale outside RUN, granted sample one cycle after the slot
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            dac_d <= MIDSCALE;
        end else if (!enable || state != S_RUN) begin
            dac_d <= MIDSCALE;
        end else if (a_ready) begin
            dac_d <= a_data;
        end else if (b_ready) begin
            dac_d <= b_data;
        end
    end

    // Underrun counter: empty slots, saturating, survives shutdown
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= '0;
        end else if (tick && !a_valid && !b_valid && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched: self-checking bench for dac_sample_sched.
// Directed bring-up / arbitration / underrun / shutdown / reset sequences,
// a table of arbitration vectors, and a randomized run against a
// schedule-based reference model (absolute cycle times for each milestone).
module tb_dac_sample_sched;

    localparam logic [9:0] MID = 10'h200;
    localparam longint FAR = 64'h3FFF_FFFF_FFFF_FFFF;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] vco_settle = '0;
    logic [11:0] cp_settle = '0;
    logic [15:0] div = '0;
    logic        prio_a = 1'b0;
    logic        a_valid = 1'b0;
    logic [9:0]  a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [9:0]  b_data = '0;
    logic        b_ready;
    logic        enb_vco;
    logic        enb_cp;
    logic [9:0]  dac_d;
    logic        running;
    logic [7:0]  underrun_cnt;

    int checks = 0;
    int errors = 0;

    dac_sample_sched dut (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (enable),
        .vco_settle   (vco_settle),
        .cp_settle    (cp_settle),
        .div          (div),
        .prio_a       (prio_a),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .enb_vco      (enb_vco),
        .enb_cp       (enb_cp),
        .dac_d        (dac_d),
        .running      (running),
        .underrun_cnt (underrun_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Returns at the falling edge of the first cycle with running high
    task automatic wait_running(input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (running) break;
        end
        if (i == lim) timeout_fail("wait_running");
    endtask

    // Returns just after the falling edge of the next cycle with a ready high
    task automatic wait_ready(input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            if (a_ready || b_ready) break;
        end
        if (i == lim) timeout_fail("wait_ready");
    endtask

    // Reference arbitration: 0 = none, 1 = A, 2 = B; last = previous rr grant
    function automatic int pick(input logic p, input logic av, input logic bv, input int last);
        if (!av && !bv) return 0;
        if (av && !bv)  return 1;
        if (bv && !av)  return 2;
        if (p)          return 1;
        return (last == 2) ? 1 : 2;
    endfunction

    typedef struct {
        logic       prio;
        logic       av;
        logic       bv;
        logic       ar;
        logic       br;
        logic [9:0] ad;
        logic [9:0] bd;
        logic [9:0] dac;
        logic [7:0] und;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic av, input logic bv,
                                input logic ar, input logic br, input logic [9:0] ad,
                                input logic [9:0] bd, input logic [9:0] dac,
                                input logic [7:0] und);
        vec_t v;
        v.prio = p; v.av = av; v.bv = bv; v.ar = ar; v.br = br;
        v.ad = ad; v.bd = bd; v.dac = dac; v.und = und;
        return v;
    endfunction

    vec_t tbl[13];

    logic [9:0] exp_dac;
    logic       e_vco, e_cp, e_run, e_a, e_b, tk;
    int         ti, tcount;

    // Model state for the randomized run
    longint     n, t_cp, t_run, nt;
    logic       m_on;
    int         m_last, g;
    logic [9:0] m_dac;
    logic [7:0] m_und;

    initial begin
        tbl[0]  = mk(0, 1, 1, 1, 0, 10'h101, 10'h081, 10'h101, 8'd0);
        tbl[1]  = mk(0, 1, 1, 0, 1, 10'h102, 10'h082, 10'h082, 8'd0);
        tbl[2]  = mk(0, 1, 0, 1, 0, 10'h103, 10'h083, 10'h103, 8'd0);
        tbl[3]  = mk(0, 1, 0, 1, 0, 10'h104, 10'h084, 10'h104, 8'd0);
        tbl[4]  = mk(0, 1, 1, 0, 1, 10'h105, 10'h085, 10'h085, 8'd0);
        tbl[5]  = mk(0, 0, 1, 0, 1, 10'h106, 10'h086, 10'h086, 8'd0);
        tbl[6]  = mk(0, 1, 1, 1, 0, 10'h107, 10'h087, 10'h107, 8'd0);
        tbl[7]  = mk(1, 1, 1, 1, 0, 10'h108, 10'h088, 10'h108, 8'd0);
        tbl[8]  = mk(1, 0, 1, 0, 1, 10'h109, 10'h089, 10'h089, 8'd0);
        tbl[9]  = mk(0, 1, 1, 0, 1, 10'h10A, 10'h08A, 10'h08A, 8'd0);
        tbl[10] = mk(0, 0, 0, 0, 0, 10'h10B, 10'h08B, 10'h08A, 8'd1);
        tbl[11] = mk(1, 0, 0, 0, 0, 10'h10C, 10'h08C, 10'h08A, 8'd2);
        tbl[12] = mk(0, 1, 1, 1, 0, 10'h10D, 10'h08D, 10'h10D, 8'd2);

        // Reset state
        #12;
        chk("reset_dac", 32'(dac_d), 32'(MID));
        chk("reset_enb", 32'({enb_vco, enb_cp, running, a_ready, b_ready}), 32'(5'b11000));
        chk("reset_und", 32'(underrun_cnt), 32'd0);
        @(negedge CLK);
        reset = 1'b1;

        // Bring-up (vco 3, cp 2) then round-robin with div=3, both sources valid
        for (int k = 0; k < 28; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                enable = 1'b1; vco_settle = 12'd3; cp_settle = 12'd2; div = 16'd3;
                prio_a = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
                a_data = 10'h011; b_data = 10'h022;
            end
            #1;
            e_vco = (k < 1);
            e_cp  = (k < 5);
            e_run = (k >= 8);
            tk    = (k >= 8) && ((k - 8) % 4 == 3);
            ti    = (k - 11) / 4;
            e_a   = tk && (ti % 2 == 0);
            e_b   = tk && (ti % 2 == 1);
            if (k <= 11) exp_dac = MID;
            else begin
                tcount  = (k - 12) / 4 + 1;
                exp_dac = ((tcount - 1) % 2 == 0) ? 10'h011 : 10'h022;
            end
            chk("bringup_enb", 32'({enb_vco, enb_cp, running}), 32'({e_vco, e_cp, e_run}));
            chk("rr_ready", 32'({a_ready, b_ready}), 32'({e_a, e_b}));
            chk("rr_dac", 32'(dac_d), 32'(exp_dac));
        end

        // Fixed priority, div=0 after next reload, A toggling, B always valid
        @(negedge CLK);
        div = 16'd0; prio_a = 1'b1;
        wait_ready(8);
        exp_dac = 10'h011;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            a_valid = (i % 2 == 0);
            a_data  = 10'h0A0 + 10'(i);
            b_data  = 10'h150 + 10'(i);
            #1;
            chk("prio_dac", 32'(dac_d), 32'(exp_dac));
            chk("prio_ready", 32'({a_ready, b_ready}), 32'({a_valid, !a_valid}));
            exp_dac = a_valid ? a_data : b_data;
        end
        chk("prio_no_underrun", 32'(underrun_cnt), 32'd0);

        // Underrun: div=1, no source valid for >300 slots
        @(negedge CLK);
        div = 16'd1; a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 620; i++) begin
            #1;
            chk("underrun_hold", 32'({dac_d, a_ready, b_ready}), 32'({exp_dac, 2'b00}));
            @(negedge CLK);
        end
        #1;
        chk("underrun_sat", 32'(underrun_cnt), 32'hFF);

        // Enable dropped on a slot with A valid
        @(negedge CLK);
        a_valid = 1'b1; a_data = 10'h3AB;
        wait_ready(4);
        @(negedge CLK);
        #1;
        chk("drop_gap_ready", 32'(a_ready), 32'd0);
        chk("drop_pre_dac", 32'(dac_d), 32'h3AB);
        @(negedge CLK);
        enable = 1'b0;
        #1;
        chk("drop_ready", 32'({a_ready, b_ready}), 32'd0);
        @(negedge CLK);
        #1;
        chk("drop_off", 32'({enb_vco, enb_cp, running, a_ready}), 32'(4'b1100));
        chk("drop_dac", 32'(dac_d), 32'(MID));
        chk("drop_und", 32'(underrun_cnt), 32'hFF);

        // Asynchronous reset in the middle of RUN with dac at 3FF
        @(negedge CLK);
        enable = 1'b1; vco_settle = '0; cp_settle = '0; div = '0;
        a_valid = 1'b1; b_valid = 1'b0; a_data = 10'h3FF;
        wait_running(10);
        @(negedge CLK);
        #1;
        chk("pre_reset_dac", 32'(dac_d), 32'h3FF);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_dac", 32'(dac_d), 32'(MID));
        chk("async_reset_out", 32'({enb_vco, enb_cp, running, a_ready, b_ready}), 32'(5'b11000));
        chk("async_reset_und", 32'(underrun_cnt), 32'd0);
        @(negedge CLK);
        enable = 1'b0; a_valid = 1'b0;
        reset = 1'b1;

        // Arbitration table, one slot per cycle (div=0)
        @(negedge CLK);
        enable = 1'b1; vco_settle = '0; cp_settle = '0; div = '0;
        wait_running(10);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin
                @(negedge CLK);
                chk("tbl_dac", 32'(dac_d), 32'(tbl[i-1].dac));
                chk("tbl_und", 32'(underrun_cnt), 32'(tbl[i-1].und));
            end
            prio_a = tbl[i].prio; a_valid = tbl[i].av; b_valid = tbl[i].bv;
            a_data = tbl[i].ad;   b_data = tbl[i].bd;
            #1;
            chk("tbl_ready", 32'({a_ready, b_ready}), 32'({tbl[i].ar, tbl[i].br}));
        end
        @(negedge CLK);
        chk("tbl_dac", 32'(dac_d), 32'(tbl[12].dac));
        chk("tbl_und", 32'(underrun_cnt), 32'(tbl[12].und));

        // Randomized run against the schedule model
        enable = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        m_on = 1'b0; m_last = 2; m_dac = MID; m_und = '0;
        t_cp = FAR; t_run = FAR; nt = FAR;
        for (n = 0; n < 4000; n++) begin
            @(negedge CLK);
            if (n == 0) enable = 1'b1;
            else if ($urandom_range(0, 99) == 0) enable = !enable;
            vco_settle = 12'($urandom_range(0, 4));
            cp_settle  = 12'($urandom_range(0, 4));
            div        = 16'($urandom_range(0, 3));
            prio_a     = 1'($urandom_range(0, 1));
            a_valid    = ($urandom_range(0, 2) != 0);
            b_valid    = ($urandom_range(0, 2) != 0);
            a_data     = 10'($urandom);
            b_data     = 10'($urandom);
            #1;
            e_run = m_on && (n >= t_run);
            tk    = e_run && (n == nt) && enable;
            g     = pick(prio_a, a_valid, b_valid, m_last);
            e_a   = tk && (g == 1);
            e_b   = tk && (g == 2);
            e_cp  = !(m_on && n >= t_cp);
            chk("rand_outputs",
                32'({a_ready, b_ready, enb_vco, enb_cp, running, dac_d, underrun_cnt}),
                32'({e_a, e_b, !m_on, e_cp, e_run, m_dac, m_und}));
            if (m_on && !enable) begin
                m_on = 1'b0; m_dac = MID;
                t_cp = FAR; t_run = FAR; nt = FAR;
            end else if (!m_on && enable) begin
                m_on = 1'b1;
                t_cp = n + 2 + longint'(vco_settle);
                t_run = FAR; nt = FAR;
            end else if (m_on) begin
                if (n == t_cp - 1)  t_run = n + 2 + longint'(cp_settle);
                if (n == t_run - 1) nt = n + 1 + longint'(div);
                if (tk) begin
                    if (g == 1)      m_dac = a_data;
                    else if (g == 2) m_dac = b_data;
                    else if (m_und != 8'hFF) m_und = m_und + 8'd1;
                    if (g != 0 && !prio_a) m_last = g;
                    nt = n + 1 + longint'(div);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
